// File: rtl/alu2_pkg.sv
// Shared definitions for the packed-BCD add/subtract unit.
//   op_e      : operation select encoding
//   NDIG_DEF  : default number of BCD digits
//   BCD_DIGIT : bits per BCD digit
package alu2_pkg;

  localparam int unsigned NDIG_DEF  = 4;
  localparam int unsigned BCD_DIGIT = 4;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

endpackage

// File: rtl/alu2_if.sv
// Operand/result bundle for alu2.
//   bcd1, bcd2     : packed-BCD operands (driven by master)
//   op_selected    : operation select (driven by master)
//   bcd_out        : registered BCD result (driven by slave)
//   special_signal : registered carry / negative / error flag (driven by slave)
interface alu2_if #(
  parameter int unsigned NDIG = alu2_pkg::NDIG_DEF
);

  logic [4*NDIG-1:0] bcd1;
  logic [4*NDIG-1:0] bcd2;
  logic [1:0]        op_selected;
  logic [4*NDIG-1:0] bcd_out;
  logic              special_signal;

  modport master (
    output bcd1,
    output bcd2,
    output op_selected,
    input  bcd_out,
    input  special_signal
  );

  modport slave (
    input  bcd1,
    input  bcd2,
    input  op_selected,
    output bcd_out,
    output special_signal
  );

endinterface

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder cell with carry in/out.
//   a, b : BCD digits (0..9)
//   cin  : carry from the less significant digit
//   s    : BCD sum digit
//   cout : carry to the more significant digit
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    s    = raw[3:0];
    cout = 1'b0;
    if (raw > 5'd9) begin
      // Adding 6 modulo 16 skips the six unused codes and lands on the BCD digit.
      s    = raw[3:0] + 4'd6;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/alu2.sv
// Registered packed-BCD add/subtract unit.
//   clk   : rising-edge clock
//   clear : synchronous active-high reset, priority over every op
//   bus   : operands, op select, registered result and flag (alu2_if slave)
// Flag meaning: carry out on add, negative on subtract, error on any invalid digit.
module alu2
  import alu2_pkg::*;
#(
  parameter int unsigned NDIG = NDIG_DEF
) (
  input  logic   clk,
  input  logic   clear,
  alu2_if.slave  bus
);

  localparam int unsigned W = BCD_DIGIT * NDIG;

  logic [W-1:0] add_res;
  logic [W-1:0] sub_raw;
  logic [W-1:0] sub_comp;
  logic         add_carry;
  logic         sub_carry;
  logic         invalid;

  logic [W-1:0] bcd_out_d, bcd_out_q;
  logic         special_d, special_q;

  // Three ripple chains per digit: A+B, A+(9-B)+1, and (9-raw)+1 for negative results.
  // Each carry lives in its own generate scope so the chain is not one self-dependent vector.
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    logic       add_ci, add_co;
    logic       sub_ci, sub_co;
    logic       cmp_ci, cmp_co;
    logic [3:0] b_nine;
    logic [3:0] raw_nine;

    if (i == 0) begin : g_first
      assign add_ci = 1'b0;
      assign sub_ci = 1'b1;
      assign cmp_ci = 1'b1;
    end else begin : g_next
      assign add_ci = g_dig[i-1].add_co;
      assign sub_ci = g_dig[i-1].sub_co;
      assign cmp_ci = g_dig[i-1].cmp_co;
    end

    assign b_nine   = 4'd9 - bus.bcd2[i*BCD_DIGIT +: BCD_DIGIT];
    assign raw_nine = 4'd9 - sub_raw[i*BCD_DIGIT +: BCD_DIGIT];

    bcd_digit_add u_add (
      .a    (bus.bcd1[i*BCD_DIGIT +: BCD_DIGIT]),
      .b    (bus.bcd2[i*BCD_DIGIT +: BCD_DIGIT]),
      .cin  (add_ci),
      .s    (add_res[i*BCD_DIGIT +: BCD_DIGIT]),
      .cout (add_co)
    );

    bcd_digit_add u_sub (
      .a    (bus.bcd1[i*BCD_DIGIT +: BCD_DIGIT]),
      .b    (b_nine),
      .cin  (sub_ci),
      .s    (sub_raw[i*BCD_DIGIT +: BCD_DIGIT]),
      .cout (sub_co)
    );

    bcd_digit_add u_cmp (
      .a    (raw_nine),
      .b    (4'd0),
      .cin  (cmp_ci),
      .s    (sub_comp[i*BCD_DIGIT +: BCD_DIGIT]),
      .cout (cmp_co)
    );
  end

  assign add_carry = g_dig[NDIG-1].add_co;
  assign sub_carry = g_dig[NDIG-1].sub_co;

  always_comb begin
    invalid = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (bus.bcd1[i*BCD_DIGIT +: BCD_DIGIT] > 4'd9 ||
          bus.bcd2[i*BCD_DIGIT +: BCD_DIGIT] > 4'd9) begin
        invalid = 1'b1;
      end
    end
  end

  always_comb begin
    bcd_out_d = bcd_out_q;
    special_d = special_q;
    unique case (op_e'(bus.op_selected))
      OP_ADD: begin
        if (invalid) begin
          bcd_out_d = '0;
          special_d = 1'b1;
        end else begin
          bcd_out_d = add_res;
          special_d = add_carry;
        end
      end
      OP_SUB: begin
        if (invalid) begin
          bcd_out_d = '0;
          special_d = 1'b1;
        end else begin
          // No final carry means A < B: report the magnitude and flag negative.
          bcd_out_d = sub_carry ? sub_raw : sub_comp;
          special_d = ~sub_carry;
        end
      end
      OP_HOLD, OP_RSVD: begin
        bcd_out_d = bcd_out_q;
        special_d = special_q;
      end
      default: begin
        bcd_out_d = bcd_out_q;
        special_d = special_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      bcd_out_q <= '0;
      special_q <= 1'b0;
    end else begin
      bcd_out_q <= bcd_out_d;
      special_q <= special_d;
    end
  end

  assign bus.bcd_out        = bcd_out_q;
  assign bus.special_signal = special_q;

endmodule

// File: tb/tb_alu2.sv
// Scoreboard bench for alu2: each applied vector pushes its hand-computed result;
// a monitor pops and compares one cycle after the sampling edge.
module tb_alu2;

  typedef struct {
    logic [15:0] bcd_out;
    logic        special;
    string       name;
  } exp_t;

  logic clk;
  logic clear;
  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  alu2_if #(.NDIG(4)) bus ();

  alu2 #(.NDIG(4)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge; the DUT samples on the next rising edge.
  task automatic apply(input logic clr, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_out,
                       input logic exp_sp, input string name);
    exp_t e;
    @(negedge clk);
    clear           = clr;
    bus.op_selected = op;
    bus.bcd1        = a;
    bus.bcd2        = b;
    e.bcd_out = exp_out;
    e.special = exp_sp;
    e.name    = name;
    exp_q.push_back(e);
  endtask

  // Monitor: result of the vector sampled at this edge is visible just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (bus.bcd_out !== e.bcd_out || bus.special_signal !== e.special) begin
          n_fail++;
          $display("FAIL %s: got bcd_out=%h special=%b, want bcd_out=%h special=%b",
                   e.name, bus.bcd_out, bus.special_signal, e.bcd_out, e.special);
        end
      end
    end
  end

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    clear           = 1'b0;
    bus.op_selected = 2'b00;
    bus.bcd1        = 16'h0000;
    bus.bcd2        = 16'h0000;
    // Arbitrary prior state before the first clear.
    @(negedge clk);
    bus.op_selected = 2'b01;
    bus.bcd1        = 16'h4321;
    bus.bcd2        = 16'h1111;
    @(negedge clk);

    apply(1'b1, 2'b01, 16'h4321, 16'h1111, 16'h0000, 1'b0, "reset");
    apply(1'b0, 2'b01, 16'h1200, 16'h2300, 16'h3500, 1'b0, "add_1200_2300");
    apply(1'b0, 2'b01, 16'h0058, 16'h0047, 16'h0105, 1'b0, "add_carry_chain");
    apply(1'b0, 2'b01, 16'h9999, 16'h0001, 16'h0000, 1'b1, "add_overflow");
    apply(1'b0, 2'b00, 16'h1234, 16'h1111, 16'h0000, 1'b1, "hold_after_overflow");
    apply(1'b0, 2'b11, 16'h5678, 16'h0101, 16'h0000, 1'b1, "hold_reserved");
    apply(1'b0, 2'b10, 16'h4500, 16'h2300, 16'h2200, 1'b0, "sub_4500_2300");
    apply(1'b0, 2'b10, 16'h1000, 16'h0001, 16'h0999, 1'b0, "sub_borrow_chain");
    apply(1'b0, 2'b10, 16'h1500, 16'h2500, 16'h1000, 1'b1, "sub_negative");
    apply(1'b0, 2'b00, 16'h0000, 16'h0000, 16'h1000, 1'b1, "hold_negative");
    apply(1'b0, 2'b10, 16'h0000, 16'h0001, 16'h0001, 1'b1, "sub_0_minus_1");
    apply(1'b0, 2'b10, 16'h4321, 16'h4321, 16'h0000, 1'b0, "sub_equal");
    apply(1'b0, 2'b01, 16'h00A0, 16'h0001, 16'h0000, 1'b1, "add_invalid_a");
    apply(1'b0, 2'b10, 16'h1234, 16'h00F0, 16'h0000, 1'b1, "sub_invalid_b");
    apply(1'b0, 2'b01, 16'h5555, 16'h4444, 16'h9999, 1'b0, "add_5555_4444");
    apply(1'b0, 2'b11, 16'h0000, 16'h0000, 16'h9999, 1'b0, "hold_9999");
    apply(1'b1, 2'b01, 16'h9999, 16'h0001, 16'h0000, 1'b0, "clear_priority");
    apply(1'b0, 2'b01, 16'h0009, 16'h0001, 16'h0010, 1'b0, "add_digit_carry");
    apply(1'b0, 2'b10, 16'h9999, 16'h0000, 16'h9999, 1'b0, "sub_minus_zero");
    apply(1'b0, 2'b01, 16'h5000, 16'h5000, 16'h0000, 1'b1, "add_5000_5000");
    apply(1'b0, 2'b10, 16'h0123, 16'h9876, 16'h9753, 1'b1, "sub_large_negative");
    apply(1'b0, 2'b10, 16'h9876, 16'h0123, 16'h9753, 1'b0, "sub_large_positive");

    @(negedge clk);
    bus.op_selected = 2'b00;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
